// File: rtl/ccd_capture_pkg.sv
// rtl/ccd_capture_pkg.sv - state encoding, default sizes and counter helper for the CCD capture front end
package ccd_capture_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_SKIP = 2'd2,
      S_CAPT = 2'd3
   } cap_state_t;

   localparam int DATA_W_DEF = 12;
   localparam int CNT_W_DEF  = 16;
   localparam int COLS_DEF   = 1280;

   // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
      logic [31:0] max_val;
      max_val = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return (v >= max_val) ? max_val : v + 32'd1;
   endfunction

endpackage

// File: rtl/ccd_sync_edge.sv
// rtl/ccd_sync_edge.sv - one-stage input register with delayed copy and rise/fall pulses
module ccd_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic q,
   output logic rise,
   output logic fall
);

   logic q_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= 1'b0;
         q_d <= 1'b0;
      end else begin
         q   <= din;
         q_d <= q;
      end
   end

   assign rise = q & ~q_d;
   assign fall = ~q & q_d;

endmodule

// File: rtl/ccd_roi_capture.sv
// rtl/ccd_roi_capture.sv - sensor capture front end with line check, ROI gate, decimation and single-shot
module ccd_roi_capture
   import ccd_capture_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int COLS   = COLS_DEF,
   parameter int FCNT_W = 32,
   parameter int SKIP_W = 4
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic [DATA_W-1:0] iDATA,
   input  logic              iFVAL,
   input  logic              iLVAL,
   input  logic              iSTART,
   input  logic              iEND,
   input  logic              iSINGLE,
   input  logic [SKIP_W-1:0] iSKIP,
   input  logic [CNT_W-1:0]  iROI_X0,
   input  logic [CNT_W-1:0]  iROI_X1,
   input  logic [CNT_W-1:0]  iROI_Y0,
   input  logic [CNT_W-1:0]  iROI_Y1,
   output logic [DATA_W-1:0] oDATA,
   output logic              oDVAL,
   output logic [CNT_W-1:0]  oX,
   output logic [CNT_W-1:0]  oY,
   output logic              oSOF,
   output logic              oEOF,
   output logic [FCNT_W-1:0] oFRAME_CNT,
   output logic              oLINE_ERR,
   output logic              oBUSY
);

   cap_state_t        state;
   logic [DATA_W-1:0] data_r;
   logic              fval_r, fval_rise, fval_fall;
   logic              lval_r, lval_rise, lval_fall;
   logic              armed, primed, seen_low;
   logic [SKIP_W-1:0] skip_cnt;
   logic [CNT_W-1:0]  sh_x0, sh_x1, sh_y0, sh_y1;
   logic              sh_single;
   logic [CNT_W-1:0]  x_cnt, y_cnt, pixel_x;
   logic              capt, frame_start, in_roi, dval;

   ccd_sync_edge u_fval_edge (
      .clk   (iCLK),
      .rst_n (iRST),
      .din   (iFVAL),
      .q     (fval_r),
      .rise  (fval_rise),
      .fall  (fval_fall)
   );

   ccd_sync_edge u_lval_edge (
      .clk   (iCLK),
      .rst_n (iRST),
      .din   (iLVAL),
      .q     (lval_r),
      .rise  (lval_rise),
      .fall  (lval_fall)
   );

   always_comb begin
      capt        = (state == S_CAPT);
      frame_start = (state == S_WAIT) && armed && fval_rise && seen_low && (skip_cnt == '0);
      // First pixel of a line is column 0 even if the counter has not been cleared yet.
      pixel_x     = lval_rise ? '0 : x_cnt;
      in_roi      = (pixel_x >= sh_x0) && (pixel_x <= sh_x1) &&
                    (y_cnt >= sh_y0) && (y_cnt <= sh_y1);
      dval        = capt && lval_r && in_roi;
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state      <= S_IDLE;
         armed      <= 1'b0;
         primed     <= 1'b0;
         seen_low   <= 1'b0;
         skip_cnt   <= '0;
         sh_x0      <= '0;
         sh_x1      <= '0;
         sh_y0      <= '0;
         sh_y1      <= '0;
         sh_single  <= 1'b0;
         oSOF       <= 1'b0;
         oEOF       <= 1'b0;
         oBUSY      <= 1'b0;
         oFRAME_CNT <= '0;
      end else begin
         oSOF     <= 1'b0;
         oEOF     <= 1'b0;
         // primed marks fval_r as holding a real sample, so a sensor mid-frame at reset release cannot start a capture.
         primed   <= 1'b1;
         seen_low <= seen_low | (primed & ~fval_r);

         if (iEND)
            armed <= 1'b0;
         else if (iSTART)
            armed <= 1'b1;

         case (state)
            S_IDLE: begin
               skip_cnt <= '0;
               if (armed)
                  state <= S_WAIT;
            end
            S_WAIT: begin
               if (!armed) begin
                  state <= S_IDLE;
               end else if (frame_start) begin
                  state      <= S_CAPT;
                  oBUSY      <= 1'b1;
                  oSOF       <= 1'b1;
                  oFRAME_CNT <= oFRAME_CNT + FCNT_W'(1);
                  skip_cnt   <= iSKIP;
                  sh_x0      <= iROI_X0;
                  sh_x1      <= iROI_X1;
                  sh_y0      <= iROI_Y0;
                  sh_y1      <= iROI_Y1;
                  sh_single  <= iSINGLE;
                  if (iSINGLE)
                     armed <= 1'b0;
               end else if (fval_rise && seen_low) begin
                  state    <= S_SKIP;
                  oBUSY    <= 1'b1;
                  skip_cnt <= skip_cnt - SKIP_W'(1);
               end
            end
            S_SKIP: begin
               if (fval_fall) begin
                  state <= S_WAIT;
                  oBUSY <= 1'b0;
               end
            end
            S_CAPT: begin
               if (fval_fall) begin
                  oEOF  <= 1'b1;
                  oBUSY <= 1'b0;
                  state <= (armed && !sh_single) ? S_WAIT : S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
               oBUSY <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         data_r    <= '0;
         oDATA     <= '0;
         oDVAL     <= 1'b0;
         oX        <= '0;
         oY        <= '0;
         x_cnt     <= '0;
         y_cnt     <= '0;
         oLINE_ERR <= 1'b0;
      end else begin
         data_r <= iDATA;
         oDATA  <= dval ? data_r : '0;
         oDVAL  <= dval;
         oX     <= pixel_x;
         oY     <= y_cnt;

         if (frame_start) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            oLINE_ERR <= 1'b0;
         end else if (capt) begin
            // A frame cut short mid-line ends without judging that line's length.
            if (fval_fall) begin
               x_cnt <= '0;
               y_cnt <= '0;
            end else if (lval_fall) begin
               x_cnt <= '0;
               y_cnt <= CNT_W'(sat_inc(32'(y_cnt), CNT_W));
               if (x_cnt != CNT_W'(COLS))
                  oLINE_ERR <= 1'b1;
            end else if (lval_r) begin
               x_cnt <= CNT_W'(sat_inc(32'(pixel_x), CNT_W));
            end
         end
      end
   end

endmodule

// File: tb/tb_ccd_roi_capture.sv
// tb/tb_ccd_roi_capture.sv - directed self-checking bench for ccd_roi_capture
module tb_ccd_roi_capture;

   localparam int DATA_W = 12;
   localparam int CNT_W  = 16;
   localparam int COLS   = 1280;
   localparam int FCNT_W = 32;
   localparam int SKIP_W = 4;

   logic              iCLK = 1'b0;
   logic              iRST = 1'b0;
   logic [DATA_W-1:0] iDATA = '0;
   logic              iFVAL = 1'b0;
   logic              iLVAL = 1'b0;
   logic              iSTART = 1'b0;
   logic              iEND = 1'b0;
   logic              iSINGLE = 1'b0;
   logic [SKIP_W-1:0] iSKIP = '0;
   logic [CNT_W-1:0]  iROI_X0 = '0;
   logic [CNT_W-1:0]  iROI_X1 = '0;
   logic [CNT_W-1:0]  iROI_Y0 = '0;
   logic [CNT_W-1:0]  iROI_Y1 = '0;
   logic [DATA_W-1:0] oDATA;
   logic              oDVAL;
   logic [CNT_W-1:0]  oX;
   logic [CNT_W-1:0]  oY;
   logic              oSOF;
   logic              oEOF;
   logic [FCNT_W-1:0] oFRAME_CNT;
   logic              oLINE_ERR;
   logic              oBUSY;

   always #5 iCLK = ~iCLK;

   ccd_roi_capture #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W),
      .COLS   (COLS),
      .FCNT_W (FCNT_W),
      .SKIP_W (SKIP_W)
   ) dut (
      .iCLK       (iCLK),
      .iRST       (iRST),
      .iDATA      (iDATA),
      .iFVAL      (iFVAL),
      .iLVAL      (iLVAL),
      .iSTART     (iSTART),
      .iEND       (iEND),
      .iSINGLE    (iSINGLE),
      .iSKIP      (iSKIP),
      .iROI_X0    (iROI_X0),
      .iROI_X1    (iROI_X1),
      .iROI_Y0    (iROI_Y0),
      .iROI_Y1    (iROI_Y1),
      .oDATA      (oDATA),
      .oDVAL      (oDVAL),
      .oX         (oX),
      .oY         (oY),
      .oSOF       (oSOF),
      .oEOF       (oEOF),
      .oFRAME_CNT (oFRAME_CNT),
      .oLINE_ERR  (oLINE_ERR),
      .oBUSY      (oBUSY)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int sof_cnt = 0, eof_cnt = 0, dval_cnt = 0, data_err = 0, zero_err = 0;
   logic first_seen = 1'b0;
   int first_x = -1, first_y = -1;
   logic err_at_sof, err_at_eof;
   logic [DATA_W-1:0] d1 = '0, d2 = '0;
   int s0, e0, v0;
   int exp_acc [7] = '{1, 0, 0, 1, 0, 0, 1};

   function automatic logic [DATA_W-1:0] pix(input int x, input int y);
      logic [31:0] xv, yv;
      xv = x;
      yv = y;
      return {yv[1:0], xv[9:0]};
   endfunction

   always @(posedge iCLK) begin
      d1 <= iDATA;
      d2 <= d1;
   end

   always @(posedge iCLK) begin
      #2;
      if (oSOF) begin
         sof_cnt++;
         err_at_sof = oLINE_ERR;
      end
      if (oEOF) begin
         eof_cnt++;
         err_at_eof = oLINE_ERR;
      end
      if (oDVAL) begin
         dval_cnt++;
         if (!first_seen) begin
            first_seen = 1'b1;
            first_x = int'(oX);
            first_y = int'(oY);
         end
         if (oDATA !== d2 || oDATA !== pix(int'(oX), int'(oY)))
            data_err++;
      end else if (oDATA !== '0) begin
         zero_err++;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge iCLK);
   endtask

   task automatic pulse_start();
      iSTART = 1'b1;
      tick(1);
      iSTART = 1'b0;
      tick(3);
   endtask

   task automatic pulse_end();
      iEND = 1'b1;
      tick(1);
      iEND = 1'b0;
      tick(3);
   endtask

   task automatic send_lines(input int lines, input int cols, input int short_line);
      for (int l = 0; l < lines; l++) begin
         int len;
         len = (l == short_line) ? cols - 1 : cols;
         for (int c = 0; c < len; c++) begin
            iLVAL = 1'b1;
            iDATA = pix(c, l);
            tick(1);
         end
         iLVAL = 1'b0;
         iDATA = '0;
         tick(8);
      end
   endtask

   task automatic send_frame(input int lines, input int cols, input int short_line);
      iFVAL = 1'b1;
      tick(3);
      send_lines(lines, cols, short_line);
      iFVAL = 1'b0;
      tick(12);
   endtask

   task automatic set_roi(input int x0, input int x1, input int y0, input int y1);
      iROI_X0 = CNT_W'(x0);
      iROI_X1 = CNT_W'(x1);
      iROI_Y0 = CNT_W'(y0);
      iROI_Y1 = CNT_W'(y1);
   endtask

   initial begin
      tick(4);
      check("rst_sof", 64'(oSOF), 64'd0);
      check("rst_eof", 64'(oEOF), 64'd0);
      check("rst_dval", 64'(oDVAL), 64'd0);
      check("rst_data", 64'(oDATA), 64'd0);
      check("rst_fcnt", 64'(oFRAME_CNT), 64'd0);
      check("rst_busy", 64'(oBUSY), 64'd0);
      check("rst_lerr", 64'(oLINE_ERR), 64'd0);
      check("rst_xy", 64'({oX, oY}), 64'd0);
      iRST = 1'b1;
      tick(4);

      // Continuous capture, full-frame ROI
      set_roi(0, 1279, 0, 3);
      iSKIP = 4'd0;
      iSINGLE = 1'b0;
      pulse_start();
      check("wait_not_busy", 64'(oBUSY), 64'd0);
      s0 = sof_cnt;
      e0 = eof_cnt;
      for (int f = 0; f < 3; f++) begin
         v0 = dval_cnt;
         send_frame(4, 1280, -1);
         check("t1_dval_per_frame", 64'(dval_cnt - v0), 64'd5120);
      end
      check("t1_sof", 64'(sof_cnt - s0), 64'd3);
      check("t1_eof", 64'(eof_cnt - e0), 64'd3);
      check("t1_fcnt", 64'(oFRAME_CNT), 64'd3);
      check("t1_lerr", 64'(oLINE_ERR), 64'd0);
      check("t1_data", 64'(data_err), 64'd0);
      check("t1_zero", 64'(zero_err), 64'd0);

      // Decimation: accept 1 of every 3
      iSKIP = 4'd2;
      for (int f = 0; f < 7; f++) begin
         s0 = sof_cnt;
         v0 = dval_cnt;
         send_frame(2, 8, -1);
         check("t2_sof", 64'(sof_cnt - s0), 64'(exp_acc[f]));
         check("t2_dval", 64'(dval_cnt - v0), 64'(exp_acc[f] * 16));
      end
      check("t2_fcnt", 64'(oFRAME_CNT), 64'd6);

      // ROI window, with a mid-frame ROI change that must be ignored
      pulse_end();
      iSKIP = 4'd0;
      set_roi(10, 19, 1, 2);
      pulse_start();
      first_seen = 1'b0;
      v0 = dval_cnt;
      iFVAL = 1'b1;
      tick(3);
      set_roi(0, 100, 0, 3);
      send_lines(4, 32, -1);
      iFVAL = 1'b0;
      tick(12);
      check("t3_dval", 64'(dval_cnt - v0), 64'd20);
      check("t3_first_x", 64'(first_x), 64'd10);
      check("t3_first_y", 64'(first_y), 64'd1);
      check("t3_data", 64'(data_err), 64'd0);
      check("t3_zero", 64'(zero_err), 64'd0);
      check("t3_fcnt", 64'(oFRAME_CNT), 64'd7);

      // Single-shot
      set_roi(0, 1279, 0, 3);
      iSINGLE = 1'b1;
      pulse_start();
      s0 = sof_cnt;
      e0 = eof_cnt;
      v0 = dval_cnt;
      send_frame(2, 8, -1);
      send_frame(2, 8, -1);
      check("t4_sof", 64'(sof_cnt - s0), 64'd1);
      check("t4_eof", 64'(eof_cnt - e0), 64'd1);
      check("t4_dval", 64'(dval_cnt - v0), 64'd16);
      check("t4_fcnt", 64'(oFRAME_CNT), 64'd8);
      check("t4_busy", 64'(oBUSY), 64'd0);

      // Line-length error: one 1279-pixel line, then a clean frame
      iSINGLE = 1'b0;
      pulse_start();
      v0 = dval_cnt;
      send_frame(4, 1280, 1);
      check("t5_sof_clear_a", 64'(err_at_sof), 64'd0);
      check("t5_err_at_eof", 64'(err_at_eof), 64'd1);
      check("t5_err_after", 64'(oLINE_ERR), 64'd1);
      check("t5_dval_short", 64'(dval_cnt - v0), 64'd5119);
      send_frame(4, 1280, -1);
      check("t5_sof_clear_b", 64'(err_at_sof), 64'd0);
      check("t5_err_clean", 64'(oLINE_ERR), 64'd0);

      // Reset released with FVAL high and START asserted
      iRST = 1'b0;
      iFVAL = 1'b1;
      iSTART = 1'b1;
      tick(3);
      iRST = 1'b1;
      tick(1);
      iSTART = 1'b0;
      s0 = sof_cnt;
      send_lines(2, 8, -1);
      check("t6_no_sof", 64'(sof_cnt - s0), 64'd0);
      check("t6_fcnt0", 64'(oFRAME_CNT), 64'd0);
      check("t6_busy0", 64'(oBUSY), 64'd0);
      iFVAL = 1'b0;
      tick(12);
      send_frame(2, 8, -1);
      check("t6_sof_clean", 64'(sof_cnt - s0), 64'd1);
      check("t6_fcnt1", 64'(oFRAME_CNT), 64'd1);

      // START and END together: END wins
      pulse_end();
      iSTART = 1'b1;
      iEND = 1'b1;
      tick(1);
      iSTART = 1'b0;
      iEND = 1'b0;
      tick(3);
      s0 = sof_cnt;
      send_frame(2, 8, -1);
      check("t7_no_sof", 64'(sof_cnt - s0), 64'd0);
      check("t7_busy", 64'(oBUSY), 64'd0);
      check("t7_fcnt", 64'(oFRAME_CNT), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
